// File: rtl/alu_arbiter.sv
// Two-requester arbiter/sequencer for the shared combinational ALU.
// Ports: clk, reset; req_* (2 requesters, valid/ready + cmd/A/B);
//   alu_* (registered ALU drive, result/flags in); rsp_* (tagged response).
// Build option: ALU_ARB_RR_EN selects round-robin, else fixed priority.
module alu_arbiter #(
    parameter int DW = 8,
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    req_valid,
    output logic [1:0]    req_ready,
    input  logic [CW-1:0] req_cmd0,
    input  logic [CW-1:0] req_cmd1,
    input  logic [DW-1:0] req_a0,
    input  logic [DW-1:0] req_a1,
    input  logic [DW-1:0] req_b0,
    input  logic [DW-1:0] req_b1,
    output logic [CW-1:0] alu_cmd,
    output logic [DW-1:0] alu_inA,
    output logic [DW-1:0] alu_inB,
    input  logic [DW-1:0] alu_rslt,
    input  logic          alu_beq,
    input  logic          alu_slt,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_rslt,
    output logic          rsp_beq,
    output logic          rsp_slt
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cmd_q;
    logic [DW-1:0] a_q;
    logic [DW-1:0] b_q;
    logic          id_q;
    logic          grant;
    logic [1:0]    ready_c;
    logic          accept;
    logic [DW-1:0] rslt_q;
    logic          beq_q;
    logic          slt_q;

`ifdef ALU_ARB_RR_EN
    // ptr names the requester that wins a tie.
    logic ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr <= 1'b0;
        else if (state == RESP && rsp_ready)
            ptr <= ~id_q;
    end

    always_comb begin
        grant = ~req_valid[0];
        if (&req_valid)
            grant = ptr;
    end
`else
    always_comb begin
        grant = ~req_valid[0];
    end
`endif

    always_comb begin
        state_nx = state;
        ready_c  = 2'b00;
        accept   = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid[grant]) begin
                    ready_c[grant] = 1'b1;
                    accept         = 1'b1;
                    state_nx       = EXEC;
                end
            end
            EXEC: state_nx = RESP;
            RESP: begin
                if (rsp_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Ready is forced low while reset is held, since the FSM sits
    // in IDLE and would otherwise advertise acceptance.
    assign req_ready = ready_c & {2{~reset}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            id_q  <= 1'b0;
        end else if (accept) begin
            cmd_q <= grant ? req_cmd1 : req_cmd0;
            a_q   <= grant ? req_a1 : req_a0;
            b_q   <= grant ? req_b1 : req_b0;
            id_q  <= grant;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rslt_q <= '0;
            beq_q  <= 1'b0;
            slt_q  <= 1'b0;
        end else if (state == EXEC) begin
            rslt_q <= alu_rslt;
            beq_q  <= alu_beq;
            slt_q  <= alu_slt;
        end
    end

    assign alu_cmd   = cmd_q;
    assign alu_inA   = a_q;
    assign alu_inB   = b_q;
    assign rsp_valid = (state == RESP);
    assign rsp_id    = id_q;
    assign rsp_rslt  = rslt_q;
    assign rsp_beq   = beq_q;
    assign rsp_slt   = slt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU model.
// Works with or without ALU_ARB_RR_EN defined.
module tb_alu_arbiter;

    logic       clk;
    logic       reset;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [4:0] req_cmd0;
    logic [4:0] req_cmd1;
    logic [7:0] req_a0;
    logic [7:0] req_a1;
    logic [7:0] req_b0;
    logic [7:0] req_b1;
    logic [4:0] alu_cmd;
    logic [7:0] alu_inA;
    logic [7:0] alu_inB;
    logic [7:0] alu_rslt;
    logic       alu_beq;
    logic       alu_slt;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [7:0] rsp_rslt;
    logic       rsp_beq;
    logic       rsp_slt;

    int n_cmp = 0;
    int n_err = 0;

    alu_arbiter #(.DW(8), .CW(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_cmd0 (req_cmd0),
        .req_cmd1 (req_cmd1),
        .req_a0   (req_a0),
        .req_a1   (req_a1),
        .req_b0   (req_b0),
        .req_b1   (req_b1),
        .alu_cmd  (alu_cmd),
        .alu_inA  (alu_inA),
        .alu_inB  (alu_inB),
        .alu_rslt (alu_rslt),
        .alu_beq  (alu_beq),
        .alu_slt  (alu_slt),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_rslt (rsp_rslt),
        .rsp_beq  (rsp_beq),
        .rsp_slt  (rsp_slt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: add, sub, else 8'h7F; flags always compare A/B.
    always_comb begin
        alu_rslt = 8'h7F;
        alu_beq  = (alu_inA == alu_inB);
        alu_slt  = ($signed(alu_inA) < $signed(alu_inB));
        if (alu_cmd == 5'b00000)
            alu_rslt = alu_inA + alu_inB;
        else if (alu_cmd == 5'b00001)
            alu_rslt = alu_inA - alu_inB;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " req_ready"}, 32'(req_ready), 0);
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, " rsp_id"}, 32'(rsp_id), 0);
        chk({tag, " rsp_rslt"}, 32'(rsp_rslt), 0);
        chk({tag, " rsp_beq"}, 32'(rsp_beq), 0);
        chk({tag, " rsp_slt"}, 32'(rsp_slt), 0);
        chk({tag, " alu_cmd"}, 32'(alu_cmd), 0);
        chk({tag, " alu_inA"}, 32'(alu_inA), 0);
        chk({tag, " alu_inB"}, 32'(alu_inB), 0);
    endtask

    // One transaction with rsp_ready held high.
    task automatic txn(input string tag, input logic id,
                       input logic [4:0] cmd, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] r,
                       input logic eq, input logic lt);
        int n;
        if (id) begin
            req_cmd1 = cmd; req_a1 = a; req_b1 = b;
        end else begin
            req_cmd0 = cmd; req_a0 = a; req_b0 = b;
        end
        req_valid[id] = 1'b1;
        #1;
        n = 0;
        while (!req_ready[id] && n < 10) begin
            tick(); #3; n++;
        end
        chk({tag, " accept"}, 32'(req_ready), id ? 2 : 1);
        tick();
        req_valid[id] = 1'b0;
        #3;
        chk({tag, " exec cmd"}, 32'(alu_cmd), 32'(cmd));
        chk({tag, " exec A"}, 32'(alu_inA), 32'(a));
        chk({tag, " exec B"}, 32'(alu_inB), 32'(b));
        chk({tag, " exec ready"}, 32'(req_ready), 0);
        chk({tag, " exec valid"}, 32'(rsp_valid), 0);
        tick(); #3;
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 1);
        chk({tag, " rsp_id"}, 32'(rsp_id), 32'(id));
        chk({tag, " rsp_rslt"}, 32'(rsp_rslt), 32'(r));
        chk({tag, " rsp_beq"}, 32'(rsp_beq), 32'(eq));
        chk({tag, " rsp_slt"}, 32'(rsp_slt), 32'(lt));
        tick(); #3;
        chk({tag, " rsp drop"}, 32'(rsp_valid), 0);
    endtask

    initial begin
        logic [7:0] hold_r;
        logic       exp_id [4];
        int         n;
`ifdef ALU_ARB_RR_EN
        exp_id = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_id = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        reset     = 1'b1;
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        req_cmd0 = '0; req_a0 = '0; req_b0 = '0;
        req_cmd1 = '0; req_a1 = '0; req_b1 = '0;
        repeat (2) @(posedge clk);
        #4;
        chk_zero("reset");
        reset = 1'b0;

        txn("add", 1'b0, 5'b00000, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0);
        txn("sub", 1'b1, 5'b00001, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b1);
        txn("beq", 1'b1, 5'b00001, 8'h2A, 8'h2A, 8'h00, 1'b1, 1'b0);

        // Contention: both requesters valid for four transactions.
        req_cmd0 = 5'b00000; req_a0 = 8'h10; req_b0 = 8'h01;
        req_cmd1 = 5'b00001; req_a1 = 8'h20; req_b1 = 8'h04;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                tick(); #3; n++;
            end while (!rsp_valid && n < 10);
            chk($sformatf("cont%0d valid", k), 32'(rsp_valid), 1);
            chk($sformatf("cont%0d id", k), 32'(rsp_id),
                32'(exp_id[k]));
            chk($sformatf("cont%0d rslt", k), 32'(rsp_rslt),
                exp_id[k] ? 32'h1C : 32'h11);
        end
        tick();
        req_valid = 2'b00;
        #3;
        chk("cont done", 32'(rsp_valid), 0);

        // Backpressure in RESP for five cycles.
        rsp_ready = 1'b0;
        req_cmd1 = 5'b00000; req_a1 = 8'h07; req_b1 = 8'h09;
        req_valid = 2'b10;
        #1;
        chk("bp accept", 32'(req_ready), 2);
        tick();
        req_valid = 2'b00;
        tick(); #3;
        chk("bp valid", 32'(rsp_valid), 1);
        chk("bp rslt", 32'(rsp_rslt), 8'h10);
        hold_r = 8'h10;
        req_cmd0 = 5'b00001; req_a0 = 8'h55; req_b0 = 8'h11;
        req_valid = 2'b11;
        for (int k = 0; k < 5; k++) begin
            tick(); #3;
            chk("bp hold valid", 32'(rsp_valid), 1);
            chk("bp hold id", 32'(rsp_id), 1);
            chk("bp hold rslt", 32'(rsp_rslt), 32'(hold_r));
            chk("bp hold ready", 32'(req_ready), 0);
            chk("bp hold A", 32'(alu_inA), 8'h07);
        end
        rsp_ready = 1'b1;
        tick(); #3;
        chk("bp release", 32'(rsp_valid), 0);
        chk("bp idle ready", 32'(req_ready), 1);
        req_valid = 2'b00;

        txn("unk", 1'b0, 5'b10000, 8'h12, 8'h34, 8'h7F, 1'b0, 1'b1);

        // Reset asserted mid-cycle while in EXEC.
        req_cmd0 = 5'b00000; req_a0 = 8'h01; req_b0 = 8'h02;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        #3;
        chk("rst exec A", 32'(alu_inA), 8'h01);
        reset = 1'b1;
        #1;
        chk_zero("rst mid");
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick(); #3;
            chk("rst no rsp", 32'(rsp_valid), 0);
        end
        txn("post rst", 1'b0, 5'b00000, 8'h40, 8'h01, 8'h41,
            1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
